// File: rtl/branch_resolve_unit_pkg.sv
// Shared OTTER control-transfer definitions: opcodes, branch funct3 codes
// and the resolve-unit state encoding.
package otter_defs;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
   parameter int unsigned n = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   output logic [n-1:0] count
);

   always_ff @(posedge CLK) begin
      if (RST) begin
         count <= '0;
      end else if (inc && (count != {n{1'b1}})) begin
         count <= count + n'(1);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves BRANCH/JAL/JALR: taken decision, redirect target, a fixed-length
// flush window after each taken transfer, and saturating statistics.
module branch_resolve_unit
   import otter_defs::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  imm_b,
   input  logic [XLEN-1:0]  imm_j,
   input  logic [XLEN-1:0]  imm_i,
   input  logic             br_eq,
   input  logic             br_lt,
   input  logic             br_ltu,
   output logic             redirect,
   output logic [XLEN-1:0]  target,
   output logic             flush,
   output logic             illegal,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] resolved_cnt
);

   localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);

   state_t          r_state;
   logic [FCW-1:0]  r_fcnt;
   logic            r_ready;
   logic            r_redirect;
   logic [XLEN-1:0] r_target;
   logic            r_flush;
   logic            r_illegal;

   logic            w_accept;
   logic            w_is_branch;
   logic            w_is_jal;
   logic            w_is_jalr;
   logic            w_is_ctrl;
   logic            w_br_taken;
   logic            w_bad_f3;
   logic            w_taken;
   logic            w_illegal;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;

   assign w_accept = valid_in & r_ready;

   // Decision and target for the instruction currently presented.
   always_comb begin
      w_is_branch = (opcode == OP_BRANCH);
      w_is_jal    = (opcode == OP_JAL);
      w_is_jalr   = (opcode == OP_JALR);
      w_br_taken  = 1'b0;
      w_bad_f3    = 1'b0;
      case (funct3)
         F3_BEQ:  w_br_taken = br_eq;
         F3_BNE:  w_br_taken = ~br_eq;
         F3_BLT:  w_br_taken = br_lt;
         F3_BGE:  w_br_taken = ~br_lt;
         F3_BLTU: w_br_taken = br_ltu;
         F3_BGEU: w_br_taken = ~br_ltu;
         default: w_bad_f3   = 1'b1;
      endcase
      w_is_ctrl  = w_is_branch | w_is_jal | w_is_jalr;
      w_taken    = (w_is_branch & w_br_taken) | w_is_jal | w_is_jalr;
      w_illegal  = w_is_branch & w_bad_f3;
      w_jalr_sum = rs1 + imm_i;
      if (w_is_jal) begin
         w_target = pc + imm_j;
      end else if (w_is_jalr) begin
         w_target = w_jalr_sum & ~XLEN'(1);
      end else begin
         w_target = pc + imm_b;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_fcnt     <= '0;
         r_ready    <= 1'b1;
         r_redirect <= 1'b0;
         r_target   <= '0;
         r_flush    <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_redirect <= 1'b0;
         r_illegal  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_flush <= 1'b0;
               if (w_accept) begin
                  r_illegal <= w_illegal;
                  if (w_taken) begin
                     r_redirect <= 1'b1;
                     r_target   <= w_target;
                     r_flush    <= 1'b1;
                     // A one-cycle window needs no FLUSH state at all.
                     if (FLUSH_CYCLES > 1) begin
                        r_state <= FLUSH;
                        r_ready <= 1'b0;
                        r_fcnt  <= FCW'(FLUSH_CYCLES - 1);
                     end
                  end
               end
            end
            FLUSH: begin
               if (r_fcnt == '0) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_flush <= 1'b0;
               end else begin
                  r_fcnt <= r_fcnt - FCW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_flush <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(.n(CNT_W)) u_taken_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (w_accept & w_taken),
      .count (taken_cnt)
   );

   sat_counter #(.n(CNT_W)) u_resolved_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (w_accept & w_is_ctrl),
      .count (resolved_cnt)
   );

   assign ready_out = r_ready;
   assign redirect  = r_redirect;
   assign target    = r_target;
   assign flush     = r_flush;
   assign illegal   = r_illegal;

endmodule
